synth_sequencer: RTL
====================

# synth_sequencer

Pattern step sequencer that drives the synth voice's `osc_count` and `trig` inputs, replacing the external trigger pin and static SPI pitch with a programmable looped melody. It holds a 16-entry pattern of oscillator counts with rest flags, advances on a tempo derived from the 20.48 MHz system clock, and gates `trig` per step. It sits between the SPI register block, which supplies the pattern writes and tempo settings, and `synth`, which consumes `osc_count` and `trig`.

## Interface
- `STEPS`, 16: pattern depth; power of two.
- `TICK_DIV`, 20480: clocks per tempo tick (1 ms at 20.48 MHz); must be ≥ 2.
- `clk` input 1: system clock, 20.48 MHz.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; begins or restarts playback at step 0.
- `stop` input 1: single-cycle pulse; halts playback.
- `loop` input 1: 1 wraps after `last_step`; 0 plays once and stops.
- `last_step` input 4: index of the final step in the pattern.
- `step_len` input 16: ticks per step; 0 is treated as 1.
- `gate_len` input 16: ticks `trig` stays high at the start of a step.
- `wr_en` input 1: pattern write strobe.
- `wr_addr` input 4: pattern write index.
- `wr_osc` input 32: oscillator count for the written entry.
- `wr_rest` input 1: rest flag for the written entry.
- `osc_count` output 32: to `synth.osc_count`.
- `trig` output 1: to `synth.trig`.
- `step_idx` output 4: currently playing step.
- `busy` output 1: high while in PLAY.
- `done` output 1: one-cycle pulse when a non-loop run finishes.

## Operation
- States are IDLE and PLAY. Reset enters IDLE.
- IDLE to PLAY on `start`.
  - Clears the prescaler and tick count.
  - Loads step 0.
- PLAY to IDLE in three cases:
  - `stop`, with no `done` pulse.
  - Boundary of `last_step` with `loop`=0, which pulses `done`.
  - `rst`.
- `start` in PLAY restarts at step 0 with counters cleared.
- `start` and `stop` in the same cycle: `stop` wins.
- Prescaler counts 0..`TICK_DIV`-1. A tick is its wrap cycle.
- `tick_cnt` counts 0..max(`step_len`,1)-1 and advances on ticks.
- A step boundary is a tick with `tick_cnt` at its maximum.
- At a step boundary the next index is computed as follows:
  - `step_idx`==`last_step` gives 0 if `loop`, else IDLE.
  - Otherwise `step_idx`+1, which wraps modulo `STEPS`.
- If `last_step` is changed below the current index, play continues to 15, wraps to 0, and then honours the new value.
- Step load copies the entry's oscillator count to `osc_count` and its rest flag to an internal register.
- `trig` = PLAY and not rest and `tick_cnt` < `gate_len`.
  - `gate_len` ≥ `step_len` holds `trig` high through the boundary, i.e. legato.
  - `gate_len`=0 silences all steps.
- `step_len` and `gate_len` are sampled live; a change takes effect from the next tick comparison.
- Pattern write takes one cycle and is allowed in any state.
  - The new entry becomes visible at the next load of that index.
  - The current `osc_count` is never changed by a write.
- `osc_count` holds its last value in IDLE; `trig` is 0 in IDLE.
- `rst` clears every pattern entry to osc 0 with rest=1.
- Reset values: `osc_count`=0, `trig`=0, `step_idx`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered.
- `start` sampled at edge N gives, at edge N+1:
  - `busy`=1, `step_idx`=0, `osc_count`=entry 0.
  - `trig`=1 if entry 0 is not a rest and `gate_len`>0.
- Step period is exactly `TICK_DIV`×max(`step_len`,1) clocks.
- `trig` high time is `TICK_DIV`×min(`gate_len`,`step_len`) clocks.
- Outputs for the new step update on the edge following the boundary cycle.
- `stop` at edge N gives `trig`=0 and `busy`=0 at N+1.
- `done` pulses in the same cycle `busy` falls.
- A write at edge N to the index loaded at edge N+1 is seen by that load, i.e. write-before-read.

## Structure
- Shared package `synth_seq_pkg`:
  - `OSC_W`=32, `STEP_IDX_W`=4.
  - State enum {IDLE, PLAY}.
  - Packed pattern-entry typedef {rest, osc[31:0]}.
- One sub-module, `seq_prescaler`:
  - Parameter `TICK_DIV`.
  - Inputs `clk`, `rst`, `clr`.
  - Output `tick`.
- Pattern store is a flop array inside the top; `synth` is unchanged.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset then idle:
  - Stimulus: hold `rst` 2 cycles, release.
  - Required: all outputs 0; `busy` stays 0 with no `start`.
- Basic loop:
  - Stimulus: entries 0..3 = osc 100,200,300,400, no rests; `last_step`=3, `step_len`=3, `gate_len`=2, `loop`=1; pulse `start`.
  - Required: each step lasts 12 clk with `trig` high 8 clk then low 4 clk; `osc_count` sequence 100,200,300,400,100.
- Single run:
  - Stimulus: same pattern, `loop`=0.
  - Required: `done` pulses exactly once, 48 clk after `busy` rises, coincident with `busy`=0 and `trig`=0; `osc_count` stays 400.
- Rest and legato:
  - Stimulus: entry 1 marked rest.
  - Required: `trig` stays 0 for all of step 1.
  - Stimulus: `gate_len`=5, `step_len`=3.
  - Required: `trig` is continuously 1 across the step 2→3 boundary.
- Control collisions:
  - Stimulus: `start` and `stop` in the same cycle during PLAY.
  - Required: IDLE.
  - Stimulus: `start` mid-step 2.
  - Required: `step_idx`=0 the next cycle with a full 12-clk step.
  - Stimulus: `rst` mid-step.
  - Required: reset values, and a later `start` plays all rests.
- Live write:
  - Stimulus: write entry 2 = osc 999 while step 2 plays.
  - Required: `osc_count` unchanged until the next pass, where it shows 999.
  - Stimulus: write at the boundary cycle.
  - Required: the new value is loaded immediately.

Source files
------------

// File: rtl/synth_seq_pkg.sv
// Shared types and widths for the pattern step sequencer.
package synth_seq_pkg;

   localparam int unsigned OSC_W      = 32;
   localparam int unsigned STEP_IDX_W = 4;

   typedef enum logic {IDLE, PLAY} seq_state_e;

   typedef struct packed {
      logic             rest;
      logic [OSC_W-1:0] osc;
   } pat_entry_t;

endpackage

// File: rtl/synth_sequencer_if.sv
// Control, pattern-write and voice-output bundle between the register block and the sequencer.
interface synth_sequencer_if;
   import synth_seq_pkg::*;

   logic                  start;
   logic                  stop;
   logic                  loop;
   logic [STEP_IDX_W-1:0] last_step;
   logic [15:0]           step_len;
   logic [15:0]           gate_len;
   logic                  wr_en;
   logic [STEP_IDX_W-1:0] wr_addr;
   logic [OSC_W-1:0]      wr_osc;
   logic                  wr_rest;

   logic [OSC_W-1:0]      osc_count;
   logic                  trig;
   logic [STEP_IDX_W-1:0] step_idx;
   logic                  busy;
   logic                  done;

   modport master (
      output start, stop, loop, last_step, step_len, gate_len,
      output wr_en, wr_addr, wr_osc, wr_rest,
      input  osc_count, trig, step_idx, busy, done
   );

   modport slave (
      input  start, stop, loop, last_step, step_len, gate_len,
      input  wr_en, wr_addr, wr_osc, wr_rest,
      output osc_count, trig, step_idx, busy, done
   );

endinterface

// File: rtl/seq_prescaler.sv
// Free-running tempo prescaler; tick marks the wrap cycle of a 0..TICK_DIV-1 count.
module seq_prescaler #(
   parameter int unsigned TICK_DIV = 20480
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/synth_sequencer.sv
// Looped pattern step sequencer driving the synth voice osc_count and trig.
module synth_sequencer
   import synth_seq_pkg::*;
#(
   parameter int unsigned STEPS    = 16,
   parameter int unsigned TICK_DIV = 20480
) (
   input  logic               clk,
   input  logic               rst,
   synth_sequencer_if.slave   bus
);

   localparam logic [STEP_IDX_W-1:0] IDX_MASK = STEP_IDX_W'(STEPS - 1);

   seq_state_e            state_q, state_d;
   pat_entry_t            pat_q [STEPS];
   pat_entry_t            load_entry;
   logic [OSC_W-1:0]      osc_q, osc_d;
   logic                  rest_q, rest_d;
   logic [STEP_IDX_W-1:0] step_q, step_d, load_idx;
   logic [15:0]           tick_cnt_q, tick_cnt_d, tick_max;
   logic                  trig_q, trig_d;
   logic                  done_q, done_d;
   logic                  tick, start_go, load;

   assign start_go = bus.start & ~bus.stop;
   assign tick_max = (bus.step_len == '0) ? '0 : bus.step_len - 16'd1;

   seq_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_go),
      .tick (tick)
   );

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      load       = 1'b0;
      load_idx   = '0;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_go) begin
               state_d    = PLAY;
               load       = 1'b1;
               tick_cnt_d = '0;
            end
         end
         PLAY: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (bus.start) begin
               load       = 1'b1;
               tick_cnt_d = '0;
            end else if (tick) begin
               // >= so a live step_len shrink below the count still ends the step
               if (tick_cnt_q >= tick_max) begin
                  tick_cnt_d = '0;
                  if (step_q == bus.last_step) begin
                     if (bus.loop) begin
                        load = 1'b1;
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     load     = 1'b1;
                     load_idx = (step_q + STEP_IDX_W'(1)) & IDX_MASK;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Bypass a same-edge write so the load sees the freshest entry
      if (bus.wr_en && (bus.wr_addr == load_idx)) load_entry = {bus.wr_rest, bus.wr_osc};
      else                                         load_entry = pat_q[load_idx];

      osc_d  = load ? load_entry.osc  : osc_q;
      rest_d = load ? load_entry.rest : rest_q;
      step_d = load ? load_idx        : step_q;
      trig_d = (state_d == PLAY) && !rest_d && (tick_cnt_d < bus.gate_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         osc_q      <= '0;
         rest_q     <= 1'b1;
         step_q     <= '0;
         tick_cnt_q <= '0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         osc_q      <= osc_d;
         rest_q     <= rest_d;
         step_q     <= step_d;
         tick_cnt_q <= tick_cnt_d;
         trig_q     <= trig_d;
         done_q     <= done_d;
      end
   end

   for (genvar g = 0; g < STEPS; g++) begin : g_pat
      always_ff @(posedge clk) begin
         if (rst) begin
            pat_q[g] <= '{rest: 1'b1, osc: '0};
         end else if (bus.wr_en && (bus.wr_addr == STEP_IDX_W'(g))) begin
            pat_q[g] <= '{rest: bus.wr_rest, osc: bus.wr_osc};
         end
      end
   end

   assign bus.osc_count = osc_q;
   assign bus.trig      = trig_q;
   assign bus.step_idx  = step_q;
   assign bus.busy      = (state_q == PLAY);
   assign bus.done      = done_q;

endmodule
